// File: rtl/alien_slot_scheduler.sv
// alien_slot_scheduler: fixed pool of alien slots with spawn, approach, animation, kill and breach handling
package alien_pkg;
  localparam int R_W = 8;
  typedef struct packed {
    logic           _active;
    logic [1:0]     _quadrant;
    logic [1:0]     _type;
    logic [R_W-1:0] _r;
    logic [1:0]     _frame_num;
  } alien_data_t;
endpackage

module alien_slot_scheduler
  import alien_pkg::*;
#(
  parameter int OBJ_LIMIT = 8,
  parameter int R_SPAWN   = 15,
  localparam int IW = (OBJ_LIMIT > 1) ? $clog2(OBJ_LIMIT) : 1,
  localparam int CW = $clog2(OBJ_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spawn_req,
  input  logic [1:0]        spawn_quadrant,
  input  logic [1:0]        spawn_type,
  input  logic              step_tick,
  input  logic              anim_tick,
  input  logic              kill_req,
  input  logic [1:0]        kill_quadrant,
  output alien_data_t       obj_data [0:OBJ_LIMIT-1],
  output logic              spawn_ack,
  output logic              spawn_drop,
  output logic              kill_done,
  output logic              kill_hit,
  output logic [1:0]        kill_type,
  output logic              breach,
  output logic [3:0]        breach_quadrant,
  output logic [CW-1:0]     active_count
);
  logic                 kill_found;
  logic [IW-1:0]        kill_idx;
  logic [R_W-1:0]       kill_r;
  logic                 free_found;
  logic [IW-1:0]        free_idx;
  logic [OBJ_LIMIT-1:0] kill_hot;
  logic [3:0]           bq_nxt;
  logic [CW-1:0]        count_nxt;
  alien_data_t          slot_nxt [0:OBJ_LIMIT-1];

  // kill target: closest active alien in the requested quadrant, strict < keeps the lowest index on ties
  always_comb begin
    kill_found = 1'b0;
    kill_idx   = '0;
    kill_r     = '1;
    for (int i = 0; i < OBJ_LIMIT; i++)
      if (obj_data[i]._active && obj_data[i]._quadrant == kill_quadrant && (!kill_found || obj_data[i]._r < kill_r)) begin
        kill_found = 1'b1;
        kill_idx   = IW'(i);
        kill_r     = obj_data[i]._r;
      end
  end

  // spawn target: lowest free slot as seen at the start of the cycle, so slots freed this cycle are not reused
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = OBJ_LIMIT - 1; i >= 0; i--)
      if (!obj_data[i]._active) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
  end

  // next slot state: anim and step on active slots, kill overrides step, spawn fills the chosen free slot
  always_comb begin
    kill_hot  = '0;
    bq_nxt    = '0;
    count_nxt = '0;
    slot_nxt  = obj_data;
    if (kill_req && kill_found) kill_hot[kill_idx] = 1'b1;
    for (int i = 0; i < OBJ_LIMIT; i++) begin
      if (obj_data[i]._active) begin
        if (anim_tick) slot_nxt[i]._frame_num = obj_data[i]._frame_num + 2'd1;
        if (kill_hot[i]) slot_nxt[i]._active = 1'b0;
        else if (step_tick && obj_data[i]._r == '0) begin
          slot_nxt[i]._active = 1'b0;
          bq_nxt[obj_data[i]._quadrant] = 1'b1;
        end else if (step_tick) slot_nxt[i]._r = obj_data[i]._r - 1'b1;
      end else if (spawn_req && free_found && free_idx == IW'(i))
        slot_nxt[i] = '{_active: 1'b1, _quadrant: spawn_quadrant, _type: spawn_type, _r: R_W'(R_SPAWN), _frame_num: 2'd0};
      count_nxt = count_nxt + CW'(slot_nxt[i]._active);
    end
  end

  // register slots and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obj_data        <= '{default: '0};
      spawn_ack       <= 1'b0;
      spawn_drop      <= 1'b0;
      kill_done       <= 1'b0;
      kill_hit        <= 1'b0;
      kill_type       <= '0;
      breach          <= 1'b0;
      breach_quadrant <= '0;
      active_count    <= '0;
    end else begin
      obj_data        <= slot_nxt;
      spawn_ack       <= spawn_req && free_found;
      spawn_drop      <= spawn_req && !free_found;
      kill_done       <= kill_req;
      kill_hit        <= kill_req && kill_found;
      kill_type       <= (kill_req && kill_found) ? obj_data[kill_idx]._type : 2'd0;
      breach          <= |bq_nxt;
      breach_quadrant <= bq_nxt;
      active_count    <= count_nxt;
    end
  end
endmodule

// File: tb/tb_alien_slot_scheduler.sv
// tb_alien_slot_scheduler: directed scenarios and random traffic against a slot-pool model
module tb_alien_slot_scheduler;
  import alien_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spawn_req = 1'b0, step_tick = 1'b0, anim_tick = 1'b0, kill_req = 1'b0;
  logic [1:0] spawn_quadrant = '0, spawn_type = '0, kill_quadrant = '0;
  alien_data_t obj_data [0:7];
  logic spawn_ack, spawn_drop, kill_done, kill_hit, breach;
  logic [1:0] kill_type;
  logic [3:0] breach_quadrant;
  logic [3:0] active_count;
  int total = 0, bad = 0;
  bit m_act [8];
  bit [1:0] m_q [8], m_t [8], m_f [8];
  int m_r [8];
  bit e_ack, e_drop, e_done, e_hit, e_breach;
  bit [1:0] e_type;
  bit [3:0] e_bq;
  int e_cnt;

  alien_slot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .spawn_quadrant(spawn_quadrant),
    .spawn_type(spawn_type), .step_tick(step_tick), .anim_tick(anim_tick),
    .kill_req(kill_req), .kill_quadrant(kill_quadrant), .obj_data(obj_data),
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop), .kill_done(kill_done),
    .kill_hit(kill_hit), .kill_type(kill_type), .breach(breach),
    .breach_quadrant(breach_quadrant), .active_count(active_count)
  );

  always #5 clk = ~clk;

  // model: one cycle of the rules, all decisions from the pre-cycle pool
  task automatic mdl_update(input bit rn, sr, input bit [1:0] sq, st, input bit stp, an, kr, input bit [1:0] kq);
    int tgt;
    int frees[$];
    {e_ack, e_drop, e_done, e_hit, e_breach, e_type, e_bq} = '0;
    e_cnt = 0;
    if (!rn) begin
      for (int i = 0; i < 8; i++) begin
        m_act[i] = 0; m_q[i] = 0; m_t[i] = 0; m_f[i] = 0; m_r[i] = 0;
      end
      return;
    end
    tgt = -1;
    for (int i = 0; i < 8; i++)
      if (m_act[i] && m_q[i] == kq && (tgt < 0 || m_r[i] < m_r[tgt])) tgt = i;
    for (int i = 0; i < 8; i++) if (!m_act[i]) frees.push_back(i);
    e_done = kr;
    e_hit  = kr && tgt >= 0;
    e_type = e_hit ? m_t[tgt] : 2'd0;
    e_ack  = sr && frees.size() > 0;
    e_drop = sr && frees.size() == 0;
    for (int i = 0; i < 8; i++)
      if (m_act[i]) begin
        if (an) m_f[i] = 2'((m_f[i] + 1) % 4);
        if (e_hit && i == tgt) m_act[i] = 0;
        else if (stp && m_r[i] == 0) begin m_act[i] = 0; e_bq[m_q[i]] = 1; end
        else if (stp) m_r[i] = m_r[i] - 1;
      end
    if (e_ack) begin
      m_act[frees[0]] = 1; m_q[frees[0]] = sq; m_t[frees[0]] = st; m_r[frees[0]] = 15; m_f[frees[0]] = 0;
    end
    e_breach = |e_bq;
    for (int i = 0; i < 8; i++) e_cnt += int'(m_act[i]);
  endtask

  task automatic cyc(input bit rn, sr, input bit [1:0] sq, st, input bit stp, an, kr, input bit [1:0] kq);
    rst_n = rn; spawn_req = sr; spawn_quadrant = sq; spawn_type = st;
    step_tick = stp; anim_tick = an; kill_req = kr; kill_quadrant = kq;
    mdl_update(rn, sr, sq, st, stp, an, kr, kq);
    @(posedge clk);
    #1;
    rst_n = 1; spawn_req = 0; step_tick = 0; anim_tick = 0; kill_req = 0;
  endtask

  function automatic logic [255:0] dut_snap();
    logic [255:0] s = '0;
    for (int i = 0; i < 8; i++) s = {s[239:0], 1'b0, obj_data[i]};
    return {s[239:0], 1'b0, spawn_ack, spawn_drop, kill_done, kill_hit, kill_type, breach, breach_quadrant, active_count};
  endfunction

  function automatic logic [255:0] mdl_snap();
    logic [255:0] s = '0;
    for (int i = 0; i < 8; i++) s = {s[239:0], 1'b0, m_act[i], m_q[i], m_t[i], 8'(m_r[i]), m_f[i]};
    return {s[239:0], 1'b0, e_ack, e_drop, e_done, e_hit, e_type, e_breach, e_bq, 4'(e_cnt)};
  endfunction

  task automatic test_reset();
    cyc(0, 1, 2, 1, 1, 1, 1, 2);
    total++;
    if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL reset_state dut=%h exp=%h", dut_snap(), mdl_snap()); end
    total++;
    if (active_count !== 4'd0 || spawn_ack !== 1'b0) begin bad++; $display("FAIL reset_count count=%0d ack=%b exp 0/0", active_count, spawn_ack); end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (spawn_ack !== 1'b0 || kill_done !== 1'b0) begin bad++; $display("FAIL reset_no_late_pulse ack=%b done=%b exp 0/0", spawn_ack, kill_done); end
  endtask

  task automatic test_fill();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 2'(i % 4), 2'(i % 4), 0, 0, 0, 0);
      total++;
      if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL fill_%0d dut=%h exp=%h", i, dut_snap(), mdl_snap()); end
    end
    total++;
    if (spawn_drop !== 1'b1 || spawn_ack !== 1'b0 || active_count !== 4'd8 || obj_data[7]._r !== 8'd15)
      begin bad++; $display("FAIL fill_final drop=%b ack=%b count=%0d r7=%0d exp 1/0/8/15", spawn_drop, spawn_ack, active_count, obj_data[7]._r); end
  endtask

  task automatic test_approach();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 0, 1, 0, 0, 0);
      total++;
      if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL approach_%0d dut=%h exp=%h", k, dut_snap(), mdl_snap()); end
      if (k < 16) begin
        total++;
        if (obj_data[0]._r !== 8'(15 - k) || breach !== 1'b0) begin bad++; $display("FAIL approach_r_%0d r=%0d breach=%b exp %0d/0", k, obj_data[0]._r, breach, 15 - k); end
      end
    end
    total++;
    if (breach !== 1'b1 || breach_quadrant !== 4'b0001 || obj_data[0]._active !== 1'b0 || active_count !== 4'd0)
      begin bad++; $display("FAIL approach_breach b=%b bq=%b act=%b cnt=%0d exp 1/0001/0/0", breach, breach_quadrant, obj_data[0]._active, active_count); end
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    total++;
    if (breach !== 1'b0) begin bad++; $display("FAIL approach_breach_pulse breach=%b exp 0", breach); end
  endtask

  task automatic test_kill_priority();
    bit [1:0] qs [6] = '{0, 3, 0, 2, 0, 2};
    bit [1:0] ts [6] = '{1, 0, 1, 3, 1, 2};
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, qs[i], ts[i], 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 3);
    cyc(1, 1, 2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 0, 0, 0);
    total++;
    if (obj_data[1]._r !== 8'd9 || obj_data[3]._r !== 8'd5 || obj_data[5]._r !== 8'd5)
      begin bad++; $display("FAIL kill_setup r1=%0d r3=%0d r5=%0d exp 9/5/5", obj_data[1]._r, obj_data[3]._r, obj_data[5]._r); end
    cyc(1, 0, 0, 0, 0, 0, 1, 2);
    total++;
    if (kill_done !== 1'b1 || kill_hit !== 1'b1 || kill_type !== 2'd3 || obj_data[3]._active !== 1'b0 || obj_data[5]._active !== 1'b1 || obj_data[1]._active !== 1'b1)
      begin bad++; $display("FAIL kill_tie done=%b hit=%b type=%0d a3=%b a5=%b a1=%b exp 1/1/3/0/1/1", kill_done, kill_hit, kill_type, obj_data[3]._active, obj_data[5]._active, obj_data[1]._active); end
    total++;
    if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL kill_tie_state dut=%h exp=%h", dut_snap(), mdl_snap()); end
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    total++;
    if (kill_done !== 1'b1 || kill_hit !== 1'b0 || kill_type !== 2'd0 || active_count !== 4'd5)
      begin bad++; $display("FAIL kill_miss done=%b hit=%b type=%0d cnt=%0d exp 1/0/0/5", kill_done, kill_hit, kill_type, active_count); end
  endtask

  task automatic test_collision();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i < 8; i++) cyc(1, 1, 2'(i % 4), 1, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 1, 0, 1, 0);
    total++;
    if (kill_hit !== 1'b1 || kill_type !== 2'd2 || breach !== 1'b0 || spawn_drop !== 1'b1 || spawn_ack !== 1'b0)
      begin bad++; $display("FAIL collision hit=%b type=%0d breach=%b drop=%b ack=%b exp 1/2/0/1/0", kill_hit, kill_type, breach, spawn_drop, spawn_ack); end
    total++;
    if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL collision_state dut=%h exp=%h", dut_snap(), mdl_snap()); end
  endtask

  task automatic test_anim();
    bit [1:0] exp_f [5] = '{1, 2, 3, 0, 1};
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0, 1, 0, 0);
      total++;
      if (obj_data[0]._frame_num !== exp_f[k] || obj_data[1]._frame_num !== 2'd0)
        begin bad++; $display("FAIL anim_%0d f0=%0d f1=%0d exp %0d/0", k, obj_data[0]._frame_num, obj_data[1]._frame_num, exp_f[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic any_act;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 2'(i), 2'(i), 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1, 1, 0);
    any_act = 1'b0;
    for (int i = 0; i < 8; i++) any_act |= obj_data[i]._active;
    total++;
    if (any_act !== 1'b0 || active_count !== 4'd0 || spawn_ack !== 1'b0 || kill_done !== 1'b0)
      begin bad++; $display("FAIL reset_mid any=%b cnt=%0d ack=%b done=%b exp 0/0/0/0", any_act, active_count, spawn_ack, kill_done); end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (spawn_ack !== 1'b0 || spawn_drop !== 1'b0 || dut_snap() !== mdl_snap())
      begin bad++; $display("FAIL reset_mid_after ack=%b drop=%b dut=%h exp=%h", spawn_ack, spawn_drop, dut_snap(), mdl_snap()); end
  endtask

  task automatic test_random();
    int errs = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(63) != 0, $urandom_range(9) < 4, 2'($urandom), 2'($urandom),
          $urandom_range(9) < 4, $urandom_range(9) < 3, $urandom_range(9) < 3, 2'($urandom));
      total++;
      if (dut_snap() !== mdl_snap()) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_%0d dut=%h exp=%h", k, dut_snap(), mdl_snap());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_approach();
    test_kill_priority();
    test_collision();
    test_anim();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
